// File: rtl/rle_decode_pkg.sv
// Shared run-length coding definitions: state encoding and default widths,
// common to the run-length encoder and decoder.
package rle_decode_pkg;

  localparam int RLE_DW = 8;
  localparam int RLE_CW = 3;

  localparam logic [15:0] TOTAL_MAX = 16'hFFFF;

  typedef enum logic {
    IDLE = 1'b0,
    EMIT = 1'b1
  } rle_state_e;

endpackage

// File: rtl/rle_decode_reg.sv
// Enable/reset storage register: synchronous active-low clear, load on enable.
module rle_decode_reg #(
  parameter int W = 8
) (
  input  logic         CLK,
  input  logic         RST,
  input  logic         en_i,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] val_q;

  // Clear on reset, otherwise load when enabled.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      val_q <= '0;
    end else if (en_i) begin
      val_q <= d_i;
    end
  end

  assign q_o = val_q;

endmodule

// File: rtl/rle_decode.sv
// Run-length decoder: expands (symbol, count) pairs into a symbol stream with
// valid/ready handshakes on both sides and a saturating emitted-symbol total.
module rle_decode
  import rle_decode_pkg::*;
#(
  parameter int DW = RLE_DW,
  parameter int CW = RLE_CW
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          IN_VALID,
  output logic          IN_READY,
  input  logic [DW-1:0] IN_DATA,
  input  logic [CW-1:0] IN_COUNT,
  output logic          OUT_VALID,
  input  logic          OUT_READY,
  output logic [DW-1:0] OUT_DATA,
  output logic [15:0]   OUT_TOTAL
);

  // Remaining-count register is one bit wider so a full 2^CW run fits.
  localparam int unsigned RUN_MAX_I = 1 << CW;
  localparam logic [CW:0] RUN_MAX   = RUN_MAX_I[CW:0];
  localparam logic [CW:0] R_ONE     = {{CW{1'b0}}, 1'b1};

  // A count of zero stands for the longest run.
  function automatic logic [CW:0] run_len(input logic [CW-1:0] cnt);
    return (cnt == '0) ? RUN_MAX : {1'b0, cnt};
  endfunction

  function automatic logic [15:0] sat_inc(input logic [15:0] v);
    return (v == TOTAL_MAX) ? v : v + 16'd1;
  endfunction

  rle_state_e    state_q, state_d;
  logic [CW:0]   r_q, r_d;
  logic          r_en;
  logic [DW-1:0] data_q;
  logic          data_en;
  logic [15:0]   total_q;
  logic          total_en;
  logic          in_acc;
  logic          out_hs;

  assign OUT_VALID = (state_q == EMIT);
  assign out_hs    = OUT_VALID && OUT_READY;
  // Ready when empty, or when the last symbol of the run leaves this cycle,
  // which lets the next run follow without a bubble.
  assign IN_READY  = RST && ((state_q == IDLE) || ((r_q == R_ONE) && OUT_READY));
  assign in_acc    = IN_VALID && IN_READY;
  assign total_en  = out_hs && (total_q != TOTAL_MAX);

  assign OUT_DATA  = data_q;
  assign OUT_TOTAL = total_q;

  // State register.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state, run-count and symbol load control.
  always_comb begin
    state_d = state_q;
    r_d     = r_q;
    r_en    = 1'b0;
    data_en = 1'b0;
    if (in_acc) begin
      state_d = EMIT;
      r_d     = run_len(IN_COUNT);
      r_en    = 1'b1;
      data_en = 1'b1;
    end else if (out_hs) begin
      r_en = 1'b1;
      if (r_q == R_ONE) begin
        state_d = IDLE;
        r_d     = '0;
      end else begin
        r_d = r_q - R_ONE;
      end
    end
  end

  rle_decode_reg #(.W(DW)) u_data (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (data_en),
    .d_i  (IN_DATA),
    .q_o  (data_q)
  );

  rle_decode_reg #(.W(CW + 1)) u_run (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (r_en),
    .d_i  (r_d),
    .q_o  (r_q)
  );

  rle_decode_reg #(.W(16)) u_total (
    .CLK  (CLK),
    .RST  (RST),
    .en_i (total_en),
    .d_i  (sat_inc(total_q)),
    .q_o  (total_q)
  );

endmodule
